// File: rtl/vm1_busctl_if.sv
// External bus of the VM1 bus controller: address/data strobes, byte
// qualifier and the slave reply handshake.
interface vm1_busctl_if;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_sync;
  logic        bus_din;
  logic        bus_dout;
  logic        bus_wtbt;
  logic        bus_rply;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_sync,
    output bus_din,
    output bus_dout,
    output bus_wtbt,
    input  bus_rdata,
    input  bus_rply
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_sync,
    input  bus_din,
    input  bus_dout,
    input  bus_wtbt,
    output bus_rdata,
    output bus_rply
  );
endinterface

// File: rtl/vm1_busctl.sv
// VM1 bus controller: turns datapath read/write requests into framed
// external bus cycles (ADDR -> DATA -> RELEASE) with reply handshake,
// bus-error timeout and a one-cycle completion pulse.
module vm1_busctl #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         rd_req,
  input  logic         wr_req,
  input  logic         byte_op,
  input  logic [15:0]  addr,
  input  logic [15:0]  wdata,
  output logic [15:0]  rdata,
  output logic         done,
  output logic         buserr,
  vm1_busctl_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR    = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  // Byte writes replicate the low byte on both lanes; the slave picks the
  // lane from address bit 0.
  function automatic logic [15:0] lane_data(input logic [15:0] d, input logic is_byte);
    logic [15:0] r;
    if (is_byte) begin
      r = {d[7:0], d[7:0]};
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Word writes are always even-aligned on the bus; reads and byte writes
  // keep address bit 0.
  function automatic logic [15:0] cycle_addr(input logic [15:0] a, input logic is_write,
                                             input logic is_byte);
    logic [15:0] r;
    if (is_write && !is_byte) begin
      r = {a[15:1], 1'b0};
    end else begin
      r = a;
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc_s;
  logic        err_q, err_d;
  logic        accept_s;
  logic        leave_s;
  logic        write_q;
  logic        byte_q;
  logic [15:0] rdata_q;
  logic        done_q;
  logic        buserr_q;
  logic [15:0] bus_addr_q;
  logic [15:0] bus_wdata_q;
  logic        sync_q;
  logic        din_q;
  logic        dout_q;
  logic        wtbt_q;

  // Saturating increment: the wait counter never wraps back to zero.
  assign cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

  // Next-state, wait-counter and error-flag decode for the bus cycle FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    accept_s = 1'b0;
    leave_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q high means this is the completion cycle: no new accept yet.
        if ((rd_req || wr_req) && !done_q) begin
          accept_s = 1'b1;
          err_d    = 1'b0;
          state_d  = ST_ADDR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        cnt_d   = 8'd0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        cnt_d = cnt_inc_s;
        if (bus.bus_rply) begin
          state_d = ST_RELEASE;
        end else if (cnt_inc_s >= TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RELEASE: begin
        // After a timeout the slave is not answering, so do not wait on it.
        if (err_q || !bus.bus_rply) begin
          leave_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered strobes/pulses, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      buserr_q <= 1'b0;
      sync_q   <= 1'b0;
      din_q    <= 1'b0;
      dout_q   <= 1'b0;
      wtbt_q   <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= leave_s;
      buserr_q <= leave_s && err_q;
      sync_q   <= (state_d != ST_IDLE);
      din_q    <= (state_d == ST_DATA) && !write_q;
      dout_q   <= (state_d == ST_DATA) && write_q;
      wtbt_q   <= (state_d == ST_DATA) && write_q && byte_q;
    end
  end

  // Request latch at acceptance and read-data capture on the reply edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 16'h0000;
      rdata_q     <= 16'h0000;
    end else if (ce) begin
      if (accept_s) begin
        // Write wins when both requests are up; the read waits in IDLE.
        write_q     <= wr_req;
        byte_q      <= wr_req && byte_op;
        bus_addr_q  <= cycle_addr(addr, wr_req, byte_op);
        bus_wdata_q <= lane_data(wdata, wr_req && byte_op);
      end
      if ((state_q == ST_DATA) && bus.bus_rply && !write_q) begin
        rdata_q <= bus.bus_rdata;
      end
    end
  end

  assign rdata         = rdata_q;
  assign done          = done_q;
  assign buserr        = buserr_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_sync  = sync_q;
  assign bus.bus_din   = din_q;
  assign bus.bus_dout  = dout_q;
  assign bus.bus_wtbt  = wtbt_q;

endmodule
